sprite_mover: RTL and testbench

Parametrised keyboard-driven sprite position controller: the next generation of the team's single-sprite mover. Decodes PS/2 arrow-key scancodes into a direction state machine and steps an (x, y) position on a divided clock-enable tick, clamped to a configurable playfield rectangle. Sits between the PS/2 keycode decoder and the VGA sprite renderer. Unlike the previous mover, it runs entirely in one clock domain and never wraps past the screen edge.

---
 rtl/sprite_pkg.sv | 22 ++
 rtl/tick_gen.sv | 34 +++
 rtl/sprite_mover.sv | 192 +++++++++++++++++++
 tb/tb_sprite_mover.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite movement and rendering blocks.
//   dir_e      - 3-bit direction state codes used by sprite_mover
//   KEY_*      - PS/2 arrow-key scancodes (KEY_NONE means no key held)
// This package has no ports.

package sprite_pkg;

    typedef enum logic [2:0] {
        DIR_IDLE  = 3'd0,
        DIR_RIGHT = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_UP    = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_e;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running divider that produces a one-cycle clock-enable pulse
// every DIV clk cycles. The count runs 0..DIV-1 and the pulse is high while
// the count sits at DIV-1, so the first pulse lands on the DIV-th edge
// after reset release.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (count returns to 0)
//   tick  out one-cycle enable pulse

module tick_gen #(
    parameter int DIV = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: keyboard-driven sprite position controller.
// Arrow-key scancodes drive a direction FSM; on each movement tick the (x, y)
// position steps in the registered direction and is clamped to the inclusive
// rectangle [X_MIN..X_MAX] x [Y_MIN..Y_MAX]. Nothing ever wraps.
//   clk      in  system clock (single clock domain)
//   rst_n    in  asynchronous active-low reset
//   keycode  in  current PS/2 scancode, level; 8'h00 = no key
//   x_pos    out registered x position
//   y_pos    out registered y position
//   state    out registered direction state (dir_e code)
//   moving   out high whenever state is not IDLE
//   hit_wall out one-cycle pulse after a tick whose step was clamped
// Build option: define SPRITE_MOVER_ACCEL_EN to let the step grow by one per
// tick held in a direction, saturating at SPEED_MAX. Without it the step is
// the constant SPEED.

module sprite_mover
    import sprite_pkg::*;
#(
    parameter int POS_W     = 10,
    parameter int SPEED     = 4,
    parameter int SPEED_MAX = 12,
    parameter int TICK_DIV  = 1000000,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479,
    parameter int X_INIT    = 50,
    parameter int Y_INIT    = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       keycode,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic [2:0]       state,
    output logic             moving,
    output logic             hit_wall
);

    localparam logic [2:0] S_IDLE  = DIR_IDLE;
    localparam logic [2:0] S_RIGHT = DIR_RIGHT;
    localparam logic [2:0] S_LEFT  = DIR_LEFT;
    localparam logic [2:0] S_UP    = DIR_UP;
    localparam logic [2:0] S_DOWN  = DIR_DOWN;

    // Bounds widened by one bit so sums and differences never wrap.
    localparam logic [POS_W:0]   X_LO  = (POS_W+1)'(X_MIN);
    localparam logic [POS_W:0]   X_HI  = (POS_W+1)'(X_MAX);
    localparam logic [POS_W:0]   Y_LO  = (POS_W+1)'(Y_MIN);
    localparam logic [POS_W:0]   Y_HI  = (POS_W+1)'(Y_MAX);
    localparam logic [POS_W-1:0] X_RST = POS_W'(X_INIT);
    localparam logic [POS_W-1:0] Y_RST = POS_W'(Y_INIT);

    // The step field is sized for the larger of base and ceiling so the
    // ceiling can never be truncated below the base step.
    localparam int STEP_TOP = (SPEED_MAX > SPEED) ? SPEED_MAX : SPEED;
    localparam int STEP_W   = $clog2(STEP_TOP + 1);
    localparam logic [STEP_W-1:0] STEP_BASE = STEP_W'(SPEED);

    logic             tick;
    logic [2:0]       state_next;
    logic [STEP_W-1:0] step;
    logic [POS_W:0]   step_ext;
    logic [POS_W:0]   axis_res;
    logic [POS_W-1:0] x_next;
    logic [POS_W-1:0] y_next;
    logic             clamped;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Increasing step; result is {clamped, new_position}.
    function automatic logic [POS_W:0] step_up(input logic [POS_W-1:0] pos,
                                               input logic [POS_W:0]   amt,
                                               input logic [POS_W:0]   hi);
        logic [POS_W:0] sum;
        sum = {1'b0, pos} + amt;
        if (sum > hi) step_up = {1'b1, hi[POS_W-1:0]};
        else          step_up = {1'b0, sum[POS_W-1:0]};
    endfunction

    // Decreasing step; compares against lo+amt so the subtraction never underflows.
    function automatic logic [POS_W:0] step_down(input logic [POS_W-1:0] pos,
                                                 input logic [POS_W:0]   amt,
                                                 input logic [POS_W:0]   lo);
        logic [POS_W:0] diff;
        diff = {1'b0, pos} - amt;
        if ({1'b0, pos} < lo + amt) step_down = {1'b1, lo[POS_W-1:0]};
        else                        step_down = {1'b0, diff[POS_W-1:0]};
    endfunction

    // Direction FSM: a direction is only reachable from IDLE, so switching
    // keys always passes through one IDLE cycle. Unused codes fall to IDLE.
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE: begin
                case (keycode)
                    KEY_RIGHT: state_next = S_RIGHT;
                    KEY_LEFT:  state_next = S_LEFT;
                    KEY_UP:    state_next = S_UP;
                    KEY_DOWN:  state_next = S_DOWN;
                    default:   state_next = S_IDLE;
                endcase
            end
            S_RIGHT: if (keycode == KEY_RIGHT) state_next = S_RIGHT;
            S_LEFT:  if (keycode == KEY_LEFT)  state_next = S_LEFT;
            S_UP:    if (keycode == KEY_UP)    state_next = S_UP;
            S_DOWN:  if (keycode == KEY_DOWN)  state_next = S_DOWN;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    assign moving = (state != S_IDLE);

`ifdef SPRITE_MOVER_ACCEL_EN
    // Step restarts from the base value whenever the FSM idles, and grows by
    // one on every tick spent in a direction until it reaches the ceiling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= STEP_BASE;
        end else if (state == S_IDLE) begin
            step <= STEP_BASE;
        end else if (tick && (step < STEP_W'(SPEED_MAX))) begin
            step <= step + STEP_W'(1);
        end
    end
`else
    // Fixed step: no register, just the base speed.
    assign step = STEP_BASE;
`endif

    assign step_ext = (POS_W+1)'(step);

    // Candidate position for this cycle, computed from the registered state
    // so a key change landing on a tick edge still moves the old way.
    always_comb begin
        axis_res = '0;
        x_next   = x_pos;
        y_next   = y_pos;
        clamped  = 1'b0;
        case (state)
            S_RIGHT: begin
                axis_res = step_up(x_pos, step_ext, X_HI);
                x_next   = axis_res[POS_W-1:0];
                clamped  = axis_res[POS_W];
            end
            S_LEFT: begin
                axis_res = step_down(x_pos, step_ext, X_LO);
                x_next   = axis_res[POS_W-1:0];
                clamped  = axis_res[POS_W];
            end
            S_UP: begin
                axis_res = step_up(y_pos, step_ext, Y_HI);
                y_next   = axis_res[POS_W-1:0];
                clamped  = axis_res[POS_W];
            end
            S_DOWN: begin
                axis_res = step_down(y_pos, step_ext, Y_LO);
                y_next   = axis_res[POS_W-1:0];
                clamped  = axis_res[POS_W];
            end
            default: ;
        endcase
    end

    // Position commits only on ticks; hit_wall is a single-cycle pulse
    // raised by a clamped tick and dropped on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos    <= X_RST;
            y_pos    <= Y_RST;
            hit_wall <= 1'b0;
        end else begin
            hit_wall <= tick & clamped;
            if (tick) begin
                x_pos <= x_next;
                y_pos <= y_next;
            end
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: directed testbench for sprite_mover.
// Two instances share clock, reset and keycode: dut_a uses the default
// playfield with TICK_DIV=4 and SPEED_MAX=6, dut_c narrows X_MAX to 60 so
// the right wall is reached within a few ticks.

module tb_sprite_mover;
    import sprite_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] keycode;

    logic [9:0] xa, ya, xc, yc;
    logic [2:0] sa, sc;
    logic       ma, mc, ha, hc;

    int tests_run    = 0;
    int tests_failed = 0;

    sprite_mover #(
        .POS_W(10), .SPEED(4), .SPEED_MAX(6), .TICK_DIV(4),
        .X_MIN(0), .X_MAX(639), .Y_MIN(0), .Y_MAX(479),
        .X_INIT(50), .Y_INIT(50)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .keycode(keycode),
        .x_pos(xa), .y_pos(ya), .state(sa), .moving(ma), .hit_wall(ha)
    );

    sprite_mover #(
        .POS_W(10), .SPEED(4), .SPEED_MAX(12), .TICK_DIV(4),
        .X_MIN(0), .X_MAX(60), .Y_MIN(0), .Y_MAX(479),
        .X_INIT(50), .Y_INIT(50)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .keycode(keycode),
        .x_pos(xc), .y_pos(yc), .state(sc), .moving(mc), .hit_wall(hc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n rising edges; outputs are observed 1 time unit after each.
    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset with the given key already held; release lands just after an
    // edge, so the next edge is edge 1 after release.
    task automatic reset_release(input logic [7:0] key);
        rst_n   = 1'b0;
        keycode = key;
        edges(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        keycode = KEY_RIGHT;
        edges(3);
        tests_run++; if (xa !== 10'd50) begin tests_failed++; $display("[TB] FAIL reset_x: got %0d want 50", xa); end
        tests_run++; if (ya !== 10'd50) begin tests_failed++; $display("[TB] FAIL reset_y: got %0d want 50", ya); end
        tests_run++; if (sa !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d want 0", sa); end
        tests_run++; if (ma !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_moving: got %0b want 0", ma); end
        tests_run++; if (ha !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hit: got %0b want 0", ha); end
        tests_run++; if (xc !== 10'd50) begin tests_failed++; $display("[TB] FAIL reset_xc: got %0d want 50", xc); end
    endtask

    task automatic test_right_move;
        reset_release(KEY_RIGHT);
        edges(1);
        tests_run++; if (sa !== 3'd1) begin tests_failed++; $display("[TB] FAIL right_state_latency: got %0d want 1", sa); end
        tests_run++; if (ma !== 1'b1) begin tests_failed++; $display("[TB] FAIL right_moving: got %0b want 1", ma); end
        edges(2);
        tests_run++; if (xa !== 10'd50) begin tests_failed++; $display("[TB] FAIL right_before_tick: got %0d want 50", xa); end
        edges(1);
        tests_run++; if (xa !== 10'd54) begin tests_failed++; $display("[TB] FAIL right_first_tick: got %0d want 54", xa); end
        tests_run++; if (ha !== 1'b0) begin tests_failed++; $display("[TB] FAIL right_no_hit: got %0b want 0", ha); end
        edges(8);
        tests_run++; if (xa !== 10'd62) begin tests_failed++; $display("[TB] FAIL right_three_ticks: got %0d want 62", xa); end
        tests_run++; if (ya !== 10'd50) begin tests_failed++; $display("[TB] FAIL right_y_hold: got %0d want 50", ya); end
        tests_run++; if (sa !== 3'd1) begin tests_failed++; $display("[TB] FAIL right_state_held: got %0d want 1", sa); end
    endtask

    // Continues from test_right_move (edge 12, tick phase back at 0).
    task automatic test_release_and_change;
        keycode = KEY_NONE;
        edges(1);
        tests_run++; if (sa !== 3'd0) begin tests_failed++; $display("[TB] FAIL release_state: got %0d want 0", sa); end
        tests_run++; if (ma !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_moving: got %0b want 0", ma); end
        edges(3);
        tests_run++; if (xa !== 10'd62) begin tests_failed++; $display("[TB] FAIL release_frozen: got %0d want 62", xa); end
        keycode = KEY_DOWN;
        edges(1);
        tests_run++; if (sa !== 3'd4) begin tests_failed++; $display("[TB] FAIL down_state: got %0d want 4", sa); end
        edges(3);
        tests_run++; if (ya !== 10'd46) begin tests_failed++; $display("[TB] FAIL down_tick1: got %0d want 46", ya); end
        edges(4);
        tests_run++; if (ya !== 10'd42) begin tests_failed++; $display("[TB] FAIL down_tick2: got %0d want 42", ya); end
        tests_run++; if (xa !== 10'd62) begin tests_failed++; $display("[TB] FAIL down_x_hold: got %0d want 62", xa); end
        keycode = KEY_RIGHT;
        edges(1);
        tests_run++; if (sa !== 3'd0) begin tests_failed++; $display("[TB] FAIL change_idle_cycle: got %0d want 0", sa); end
        edges(1);
        tests_run++; if (sa !== 3'd1) begin tests_failed++; $display("[TB] FAIL change_new_dir: got %0d want 1", sa); end
    endtask

    task automatic test_tick_edge_key;
        reset_release(KEY_RIGHT);
        edges(3);
        keycode = KEY_NONE;
        edges(1);
        tests_run++; if (xa !== 10'd54) begin tests_failed++; $display("[TB] FAIL tickedge_old_dir: got %0d want 54", xa); end
        tests_run++; if (sa !== 3'd0) begin tests_failed++; $display("[TB] FAIL tickedge_state: got %0d want 0", sa); end
    endtask

    task automatic test_clamp;
        reset_release(KEY_RIGHT);
        edges(4);
        tests_run++; if (xc !== 10'd54) begin tests_failed++; $display("[TB] FAIL clamp_tick1: got %0d want 54", xc); end
        tests_run++; if (hc !== 1'b0) begin tests_failed++; $display("[TB] FAIL clamp_hit1: got %0b want 0", hc); end
        edges(4);
        tests_run++; if (xc !== 10'd58) begin tests_failed++; $display("[TB] FAIL clamp_tick2: got %0d want 58", xc); end
        edges(3);
        tests_run++; if (hc !== 1'b0) begin tests_failed++; $display("[TB] FAIL clamp_hit_between: got %0b want 0", hc); end
        edges(1);
        tests_run++; if (xc !== 10'd60) begin tests_failed++; $display("[TB] FAIL clamp_tick3: got %0d want 60", xc); end
        tests_run++; if (hc !== 1'b1) begin tests_failed++; $display("[TB] FAIL clamp_hit3: got %0b want 1", hc); end
        tests_run++; if (xa !== 10'd62) begin tests_failed++; $display("[TB] FAIL clamp_wide_x: got %0d want 62", xa); end
        edges(1);
        tests_run++; if (hc !== 1'b0) begin tests_failed++; $display("[TB] FAIL clamp_pulse_width: got %0b want 0", hc); end
        edges(3);
        tests_run++; if (xc !== 10'd60) begin tests_failed++; $display("[TB] FAIL clamp_tick4: got %0d want 60", xc); end
        tests_run++; if (hc !== 1'b1) begin tests_failed++; $display("[TB] FAIL clamp_hit4_at_bound: got %0b want 1", hc); end
    endtask

    task automatic test_bottom_clamp;
        reset_release(KEY_DOWN);
        edges(48);
        tests_run++; if (ya !== 10'd2) begin tests_failed++; $display("[TB] FAIL bottom_tick12: got %0d want 2", ya); end
        tests_run++; if (ha !== 1'b0) begin tests_failed++; $display("[TB] FAIL bottom_hit12: got %0b want 0", ha); end
        edges(4);
        tests_run++; if (ya !== 10'd0) begin tests_failed++; $display("[TB] FAIL bottom_tick13: got %0d want 0", ya); end
        tests_run++; if (ha !== 1'b1) begin tests_failed++; $display("[TB] FAIL bottom_hit13: got %0b want 1", ha); end
    endtask

    task automatic test_reset_mid_move;
        reset_release(KEY_RIGHT);
        edges(6);
        tests_run++; if (xa !== 10'd54) begin tests_failed++; $display("[TB] FAIL midreset_pre: got %0d want 54", xa); end
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++; if (xa !== 10'd50) begin tests_failed++; $display("[TB] FAIL midreset_x: got %0d want 50", xa); end
        tests_run++; if (ya !== 10'd50) begin tests_failed++; $display("[TB] FAIL midreset_y: got %0d want 50", ya); end
        tests_run++; if (sa !== 3'd0) begin tests_failed++; $display("[TB] FAIL midreset_state: got %0d want 0", sa); end
        edges(1);
        rst_n = 1'b1;
        edges(3);
        tests_run++; if (xa !== 10'd50) begin tests_failed++; $display("[TB] FAIL midreset_no_early_move: got %0d want 50", xa); end
        edges(1);
        tests_run++; if (xa !== 10'd54) begin tests_failed++; $display("[TB] FAIL midreset_first_move: got %0d want 54", xa); end
    endtask

    task automatic test_accel;
        logic [9:0] exp_x [0:4];
`ifdef SPRITE_MOVER_ACCEL_EN
        exp_x[0] = 10'd46; exp_x[1] = 10'd41; exp_x[2] = 10'd35; exp_x[3] = 10'd29; exp_x[4] = 10'd25;
`else
        exp_x[0] = 10'd46; exp_x[1] = 10'd42; exp_x[2] = 10'd38; exp_x[3] = 10'd34; exp_x[4] = 10'd30;
`endif
        reset_release(KEY_LEFT);
        for (int i = 0; i < 4; i++) begin
            edges(4);
            tests_run++;
            if (xa !== exp_x[i]) begin
                tests_failed++;
                $display("[TB] FAIL accel_tick%0d: got %0d want %0d", i + 1, xa, exp_x[i]);
            end
        end
        keycode = KEY_NONE;
        edges(1);
        tests_run++; if (sa !== 3'd0) begin tests_failed++; $display("[TB] FAIL accel_release_state: got %0d want 0", sa); end
        keycode = KEY_LEFT;
        edges(1);
        tests_run++; if (sa !== 3'd2) begin tests_failed++; $display("[TB] FAIL accel_left_state: got %0d want 2", sa); end
        edges(2);
        tests_run++; if (xa !== exp_x[4]) begin tests_failed++; $display("[TB] FAIL accel_step_restart: got %0d want %0d", xa, exp_x[4]); end
    endtask

    initial begin
        rst_n   = 1'b0;
        keycode = KEY_NONE;
        test_reset();
        test_right_move();
        test_release_and_change();
        test_tick_edge_key();
        test_clamp();
        test_bottom_clamp();
        test_reset_mid_move();
        test_accel();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
